danmaku_pixel_feeder: RTL and testbench

//   Upstream producer for the overlay stage's danmaku pixel FIFO (write side, same dcfifo).

---
 rtl/danmaku_pixel_feeder_pkg.sv | 15 +
 rtl/danmaku_pixel_feeder_rd_credit.sv | 34 +++
 rtl/danmaku_pixel_feeder.sv | 142 ++++++++++++++
 tb/tb_danmaku_pixel_feeder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/danmaku_pixel_feeder_pkg.sv
// danmaku_pkg: word formats, sync codes and feeder FSM states shared by the danmaku overlay and its pixel feeder.
package danmaku_pkg;
    localparam int FLAG_VALID_BIT = 7;
    localparam logic [1:0] SYNC_H = 2'b01;
    localparam logic [1:0] SYNC_V = 2'b10;
    localparam logic [31:0] WORD_H = {30'd0, SYNC_H};
    localparam logic [31:0] WORD_V = {30'd0, SYNC_V};
    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_VMARK, S_FETCH, S_DRAIN, S_HMARK} feeder_state_t;
    function automatic logic [31:0] pixel_word(input logic [31:0] argb);
        logic [7:0] flags;
        flags = '0;
        flags[FLAG_VALID_BIT] = argb[31];
        return {argb[23:0], flags};
    endfunction
endpackage

// File: rtl/danmaku_pixel_feeder_rd_credit.sv
// danmaku_rd_credit: in-flight read counter and FIFO credit check for the pixel feeder.
module danmaku_rd_credit #(
    parameter int FIFO_DEPTH = 512,
    parameter int USEDW_W = 9,
    parameter int MAX_OUTST = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_accept,
    input  logic               i_rdvalid,
    input  logic               i_wr_pend,
    input  logic [USEDW_W-1:0] i_usedw,
    output logic [USEDW_W+1:0] o_outst,
    output logic               o_read_ok,
    output logic               o_mark_ok
);
    localparam int FW = USEDW_W + 2;
    logic [FW-1:0] r_outst;
    logic [FW-1:0] w_fill;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            r_outst <= '0;
        else if (i_accept && !i_rdvalid)
            r_outst <= r_outst + 1'b1;
        else if (!i_accept && i_rdvalid)
            r_outst <= r_outst - 1'b1;
    // a read accepted this cycle already owns a FIFO slot for the next issue decision
    always_comb begin
        w_fill = FW'(i_usedw) + r_outst + FW'(i_wr_pend) + FW'(i_accept);
        o_read_ok = (w_fill < FW'(FIFO_DEPTH - 2)) && (r_outst + FW'(i_accept) < FW'(MAX_OUTST));
        o_mark_ok = w_fill < FW'(FIFO_DEPTH - 1);
    end
    assign o_outst = r_outst;
endmodule

// File: rtl/danmaku_pixel_feeder.sv
// danmaku_pixel_feeder: streams a frame-sized ARGB bitmap from Avalon-MM memory into the danmaku FIFO,
// framing it with a V-marker per frame and an H-marker before every line after the first.
module danmaku_pixel_feeder
    import danmaku_pkg::*;
#(
    parameter int FIFO_DEPTH = 512,
    parameter int USEDW_W = 9,
    parameter int MAX_OUTST = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [31:0]        frameBase,
    input  logic [15:0]        screenX,
    input  logic [15:0]        screenY,
    output logic [31:0]        avm_address,
    output logic               avm_read,
    input  logic               avm_waitrequest,
    input  logic [31:0]        avm_readdata,
    input  logic               avm_readdatavalid,
    output logic               fifoWrreq,
    output logic [31:0]        fifoData,
    input  logic [USEDW_W-1:0] fifoWrusedw,
    output logic               busy,
    output logic               frameDone,
    output logic               cfgErr
);
    feeder_state_t r_state;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_sx;
    logic [15:0] r_sy;
    logic r_read;
    logic r_wrreq;
    logic r_busy;
    logic r_done;
    logic r_cfgerr;
    logic [USEDW_W+1:0] w_outst;
    logic w_accept;
    logic w_read_ok;
    logic w_mark_ok;
    logic w_mark_go;

    assign w_accept = r_read && !avm_waitrequest;
    // markers wait for the pixel stream to fully land so FIFO word order matches issue order
    assign w_mark_go = (w_outst == '0) && !r_wrreq && w_mark_ok;

    danmaku_rd_credit #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .USEDW_W(USEDW_W),
        .MAX_OUTST(MAX_OUTST)
    ) u_credit (
        .clk(clk),
        .rst(rst),
        .i_accept(w_accept),
        .i_rdvalid(avm_readdatavalid),
        .i_wr_pend(r_wrreq),
        .i_usedw(fifoWrusedw),
        .o_outst(w_outst),
        .o_read_ok(w_read_ok),
        .o_mark_ok(w_mark_ok)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_addr <= '0;
            r_data <= '0;
            r_x <= '0;
            r_y <= '0;
            r_sx <= '0;
            r_sy <= '0;
            r_read <= 1'b0;
            r_wrreq <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cfgerr <= 1'b0;
        end else begin
            r_wrreq <= avm_readdatavalid;
            if (avm_readdatavalid)
                r_data <= pixel_word(avm_readdata);
            r_done <= 1'b0;
            if (!enable)
                r_cfgerr <= 1'b0;
            case (r_state)
                S_IDLE: if (enable) begin
                    r_state <= S_LATCH;
                    r_busy <= 1'b1;
                end
                S_LATCH: begin
                    r_sx <= screenX;
                    r_sy <= screenY;
                    r_addr <= frameBase & ~32'd3;
                    r_y <= '0;
                    if (screenX == '0 || screenY == '0) begin
                        r_cfgerr <= 1'b1;
                        r_busy <= 1'b0;
                        r_state <= S_IDLE;
                    end else
                        r_state <= S_VMARK;
                end
                S_VMARK, S_HMARK: if (w_mark_go) begin
                    r_wrreq <= 1'b1;
                    r_data <= (r_state == S_VMARK) ? WORD_V : WORD_H;
                    r_x <= '0;
                    r_state <= S_FETCH;
                end
                S_FETCH: if (w_accept) begin
                    r_addr <= r_addr + 32'd4;
                    r_x <= r_x + 1'b1;
                    if (r_x == r_sx - 1'b1) begin
                        r_read <= 1'b0;
                        r_state <= S_DRAIN;
                    end else
                        r_read <= w_read_ok;
                end else if (!r_read)
                    r_read <= w_read_ok;
                S_DRAIN: if (w_outst == '0) begin
                    if (r_y != r_sy - 1'b1) begin
                        r_y <= r_y + 1'b1;
                        r_state <= S_HMARK;
                    end else begin
                        r_done <= 1'b1;
                        r_busy <= enable;
                        r_state <= enable ? S_LATCH : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign avm_address = r_addr;
    assign avm_read = r_read;
    assign fifoWrreq = r_wrreq;
    assign fifoData = r_data;
    assign busy = r_busy;
    assign frameDone = r_done;
    assign cfgErr = r_cfgerr;
endmodule

// File: tb/tb_danmaku_pixel_feeder.sv
// tb_danmaku_pixel_feeder: directed and randomized frames against a word-list model of the feeder output.
module tb_danmaku_pixel_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic [31:0] frameBase = '0;
    logic [15:0] screenX = '0;
    logic [15:0] screenY = '0;
    logic [31:0] avm_address;
    logic avm_read;
    logic avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic avm_readdatavalid = 1'b0;
    logic fifoWrreq;
    logic [31:0] fifoData;
    logic [8:0] fifoWrusedw = '0;
    logic busy;
    logic frameDone;
    logic cfgErr;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_pct = 0;
    int lat_max = 1;
    int done_cnt = 0;
    int last_ready = 0;
    int frames = 0;
    bit fixed_en = 0;
    bit rand_usedw = 0;
    logic [31:0] fixed_data = '0;
    logic [8:0] usedw_set = '0;

    typedef struct {int ready; logic [31:0] addr;} rd_t;
    rd_t pend_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];

    always #5 clk = ~clk;

    danmaku_pixel_feeder dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .frameBase(frameBase),
        .screenX(screenX),
        .screenY(screenY),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .fifoWrreq(fifoWrreq),
        .fifoData(fifoData),
        .fifoWrusedw(fifoWrusedw),
        .busy(busy),
        .frameDone(frameDone),
        .cfgErr(cfgErr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return fixed_en ? fixed_data : ((a * 32'h9E37_79B9) ^ 32'h5A5A_1234);
    endfunction

    function automatic logic [31:0] pix(input logic [31:0] d);
        return {d[23:0], d[31], 7'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory slave, FIFO monitor and outstanding tracker all act on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            pend_q.delete();
            avm_readdatavalid = 1'b0;
            avm_waitrequest = 1'b0;
            fifoWrusedw = '0;
        end else begin
            if (fifoWrreq) begin
                chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0)
                    chk("fifo_word", fifoData, exp_q.pop_front());
            end
            if (frameDone)
                done_cnt++;
            avm_waitrequest = ($urandom_range(99) < wr_pct);
            if (pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else
                avm_readdatavalid = 1'b0;
            if (avm_read === 1'b1 && !avm_waitrequest) begin
                int r;
                chk("read_expected", 32'(addr_q.size() > 0), 32'd1);
                if (addr_q.size() > 0)
                    chk("rd_addr", avm_address, addr_q.pop_front());
                r = cyc + $urandom_range(lat_max, 1);
                if (r < last_ready)
                    r = last_ready;
                last_ready = r;
                pend_q.push_back('{r, avm_address});
                chk("outstanding_le_16", 32'(pend_q.size() <= 16), 32'd1);
            end
            fifoWrusedw = rand_usedw ? 9'($urandom_range(511, 480)) : usedw_set;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_frames(input int budget);
        int c = 0;
        while (done_cnt < frames && c < budget) begin
            step(1);
            c++;
        end
        chk("frame_done_count", done_cnt, frames);
    endtask

    task automatic push_frame(input logic [31:0] base, input int sx, input int sy);
        logic [31:0] a;
        a = base & ~32'd3;
        exp_q.push_back(32'h2);
        for (int y = 0; y < sy; y++) begin
            if (y > 0)
                exp_q.push_back(32'h1);
            for (int x = 0; x < sx; x++) begin
                addr_q.push_back(a);
                exp_q.push_back(pix(mem_word(a)));
                a += 32'd4;
            end
        end
        frames++;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_read"}, 32'(avm_read), 32'd0);
        chk({tag, "_addr"}, avm_address, 32'd0);
        chk({tag, "_wrreq"}, 32'(fifoWrreq), 32'd0);
        chk({tag, "_data"}, fifoData, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(frameDone), 32'd0);
        chk({tag, "_cfgerr"}, 32'(cfgErr), 32'd0);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_reads_left"}, 32'(addr_q.size()), 32'd0);
    endtask

    initial begin
        int rd_seen;
        int sx;
        int sy;
        #2 rst = 1'b0;
        step(2);
        check_idle_outputs("reset");
        rst = 1'b1;
        step(2);

        // 4x2 frame, zero-wait memory, alpha set: literal word sequence
        fixed_en = 1;
        fixed_data = 32'h8011_2233;
        frameBase = 32'h0000_1000;
        screenX = 16'd4;
        screenY = 16'd2;
        exp_q.push_back(32'h0000_0002);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h1122_3380);
        exp_q.push_back(32'h0000_0001);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h1122_3380);
        for (int i = 0; i < 8; i++) addr_q.push_back(32'h1000 + 32'(4 * i));
        frames++;
        enable = 1'b1;
        step(2);
        chk("busy_running", 32'(busy), 32'd1);
        enable = 1'b0;
        wait_frames(300);
        step(3);
        chk("busy_after_frame", 32'(busy), 32'd0);
        check_drained("frame4x2");

        // alpha clear
        fixed_data = 32'h0011_2233;
        screenX = 16'd3;
        screenY = 16'd1;
        frameBase = 32'h0000_2002;
        exp_q.push_back(32'h0000_0002);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h1122_3300);
            addr_q.push_back(32'h2000 + 32'(4 * i));
        end
        frames++;
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        wait_frames(300);
        step(3);
        check_drained("alpha_clear");
        fixed_en = 0;

        // address wrap across 2^32
        wr_pct = 30;
        lat_max = 4;
        frameBase = 32'hFFFF_FFF9;
        screenX = 16'd4;
        screenY = 16'd1;
        push_frame(frameBase, 4, 1);
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        wait_frames(300);
        step(3);
        check_drained("addr_wrap");

        // credit backpressure with a nearly-full FIFO
        wr_pct = 0;
        lat_max = 3;
        frameBase = 32'h0004_0000;
        screenX = 16'd64;
        screenY = 16'd2;
        push_frame(frameBase, 64, 2);
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        step(20);
        usedw_set = 9'd510;
        step(3);
        rd_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            rd_seen += int'(avm_read);
        end
        chk("read_blocked_at_510", 32'(rd_seen), 32'd0);
        usedw_set = 9'd100;
        wait_frames(2000);
        step(3);
        check_drained("backpressure");

        // full-HD width line with random stalls and return latency
        wr_pct = 50;
        lat_max = 8;
        usedw_set = 9'd0;
        frameBase = {$urandom_range(32'hFFFF), 16'h0};
        screenX = 16'd1920;
        screenY = 16'd2;
        push_frame(frameBase, 1920, 2);
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        wait_frames(40000);
        step(10);
        check_drained("line1920");

        // two back-to-back frames with enable held and a jittering fill level
        rand_usedw = 1;
        sx = $urandom_range(40, 1);
        sy = $urandom_range(4, 1);
        frameBase = $urandom;
        screenX = 16'(sx);
        screenY = 16'(sy);
        push_frame(frameBase, sx, sy);
        enable = 1'b1;
        wait_frames(20000);
        push_frame(frameBase, sx, sy);
        step(1);
        enable = 1'b0;
        wait_frames(20000);
        step(10);
        rand_usedw = 0;
        check_drained("back_to_back");
        chk("busy_after_b2b", 32'(busy), 32'd0);

        // zero height: config error, no FIFO traffic
        screenX = 16'd5;
        screenY = 16'd0;
        enable = 1'b1;
        step(6);
        chk("cfgerr_set", 32'(cfgErr), 32'd1);
        enable = 1'b0;
        step(3);
        chk("cfgerr_cleared", 32'(cfgErr), 32'd0);
        chk("cfgerr_busy", 32'(busy), 32'd0);
        chk("cfgerr_no_frame", done_cnt, frames);

        // asynchronous reset in the middle of a line
        wr_pct = 0;
        lat_max = 2;
        frameBase = 32'h0010_0000;
        screenX = 16'd1920;
        screenY = 16'd1;
        push_frame(frameBase, 1920, 1);
        frames--;
        enable = 1'b1;
        step(100);
        rst = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        exp_q.delete();
        addr_q.delete();
        enable = 1'b0;
        step(1);
        check_idle_outputs("rst_edge");
        rst = 1'b1;
        step(5);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_done_count", done_cnt, frames);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
